multi_debouncer: RTL and testbench

Parametrised multi-channel successor to the single-button debouncer. It synchronises NUM_CH raw mechanical inputs and debounces each one with its own exact-length stability counter. For each channel it produces a clean level plus single-cycle press, release and long-press event pulses. It sits between board push-buttons/switches and the user-interface control FSMs, so downstream logic never has to build its own edge detectors.

---
 rtl/multi_debouncer.sv | 107 ++++++++++
 tb/tb_multi_debouncer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// multi_debouncer
//   Multi-channel push-button/switch conditioner. Each channel is
//   synchronised with two flops and debounced with an exact-length stability
//   counter. It also produces one-cycle press, release and long-press pulses.
//   Channels are fully independent and every output is registered.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset; clears every flop and counter
//   btn_in       raw asynchronous inputs, bit i = channel i
//   btn_state    debounced level per channel, 1 = pressed
//   btn_press    one-cycle pulse in the first cycle a channel reads pressed
//   btn_release  one-cycle pulse in the first cycle a channel reads released
//   btn_long     one-cycle pulse LONG_CYCLES cycles after a press, if still held
module multi_debouncer #(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_state,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_long
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  // Hold counter increment that sticks at LONG_CYCLES so it never wraps
  // while a button stays down indefinitely.
  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] h);
    if (h == HOLD_MAX) return HOLD_MAX;
    else               return h + 1'b1;
  endfunction

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] r_sync_p0;
  logic [NUM_CH-1:0] r_sync_p1;
  logic [NUM_CH-1:0] r_state;
  logic [NUM_CH-1:0] r_press;
  logic [NUM_CH-1:0] r_release;
  logic [NUM_CH-1:0] r_long;
  logic [CNT_W-1:0]  r_cnt  [NUM_CH];
  logic [HOLD_W-1:0] r_hold [NUM_CH];

  // Normalise polarity so everything downstream treats 1 as pressed.
  assign w_raw = btn_in ^ {NUM_CH{ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]  <= '0;
        r_hold[i] <= '0;
      end
    end else begin
      // stage p0/p1: two-flop synchroniser
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;

      for (int i = 0; i < NUM_CH; i++) begin
        // stage: stability counter, counts consecutive disagreeing cycles
        r_press[i]   <= 1'b0;
        r_release[i] <= 1'b0;
        if (r_sync_p1[i] == r_state[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_state[i]   <= r_sync_p1[i];
          r_cnt[i]     <= '0;
          r_press[i]   <= r_sync_p1[i];
          r_release[i] <= ~r_sync_p1[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end

        // stage: hold counter; the pulse fires on the step that reaches
        // LONG_CYCLES, so saturation guarantees at most one per press
        if (!r_state[i]) begin
          r_hold[i] <= '0;
          r_long[i] <= 1'b0;
        end else begin
          r_hold[i] <= hold_sat_inc(r_hold[i]);
          r_long[i] <= (r_hold[i] == HOLD_LAST);
        end
      end
    end
  end

  assign btn_state   = r_state;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_long    = r_long;

endmodule

// File: tb/tb_multi_debouncer.sv
module tb_multi_debouncer;

  localparam int N  = 4;
  localparam int ST = 8;
  localparam int LG = 40;

  logic         clk = 1'b0;
  logic         rst    [2];
  logic [N-1:0] bin    [2];
  logic [N-1:0] st     [2];
  logic [N-1:0] pr     [2];
  logic [N-1:0] rl     [2];
  logic [N-1:0] lg     [2];

  always #5 clk = ~clk;

  multi_debouncer #(.NUM_CH(N), .STABLE_CYCLES(ST), .LONG_CYCLES(LG), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(rst[0]), .btn_in(bin[0]),
    .btn_state(st[0]), .btn_press(pr[0]), .btn_release(rl[0]), .btn_long(lg[0])
  );

  multi_debouncer #(.NUM_CH(N), .STABLE_CYCLES(ST), .LONG_CYCLES(LG), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(rst[1]), .btn_in(bin[1]),
    .btn_state(st[1]), .btn_press(pr[1]), .btn_release(rl[1]), .btn_long(lg[1])
  );

  typedef struct {
    int           t;
    int           id;
    logic [N-1:0] st;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] lg;
  } ev_t;

  ev_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: the synchronised level seen at edge m is the raw input
  // sampled two edges earlier (zero if reset intervened). A channel changes
  // state when its last ST synchronised samples all disagree with the
  // current state. Long press is judged by edges elapsed since the press.
  logic [N-1:0] mst   [2];
  logic [N-1:0] hist1 [2];
  logic [N-1:0] hist2 [2];
  logic [N-1:0] win   [2][ST];
  int           rawcnt[2];
  int           ns2   [2];
  int           pedge [2][N];
  logic [N-1:0] m_raw, m_s2, m_pr, m_rl, m_lg;
  logic         all_diff;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      m_raw = bin[d] ^ ((d == 1) ? 4'hF : 4'h0);
      if (rst[d]) begin
        mst[d]    = '0;
        rawcnt[d] = 0;
        ns2[d]    = 0;
        for (int c = 0; c < N; c++) pedge[d][c] = -1;
      end else begin
        m_s2     = (rawcnt[d] >= 2) ? hist2[d] : '0;
        hist2[d] = hist1[d];
        hist1[d] = m_raw;
        if (rawcnt[d] < 2) rawcnt[d]++;
        for (int k = ST - 1; k > 0; k--) win[d][k] = win[d][k-1];
        win[d][0] = m_s2;
        if (ns2[d] < ST) ns2[d]++;
        m_pr = '0;
        m_rl = '0;
        m_lg = '0;
        for (int c = 0; c < N; c++) begin
          if (mst[d][c] && pedge[d][c] >= 0 && (cyc - pedge[d][c]) == LG) m_lg[c] = 1'b1;
          if (ns2[d] == ST) begin
            all_diff = 1'b1;
            for (int k = 0; k < ST; k++)
              if (win[d][k][c] == mst[d][c]) all_diff = 1'b0;
            if (all_diff) begin
              if (mst[d][c]) m_rl[c] = 1'b1;
              else begin
                m_pr[c]     = 1'b1;
                pedge[d][c] = cyc;
              end
            end
          end
        end
        mst[d] = mst[d] ^ (m_pr | m_rl);
        if (|(m_pr | m_rl | m_lg))
          sbq.push_back('{t: cyc, id: d, st: mst[d], pr: m_pr, rl: m_rl, lg: m_lg});
      end
    end
  end

  // Monitor: level checked every cycle, pulses matched against the scoreboard.
  bit  have_exp;
  bit  have_act;
  ev_t e;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (st[d] !== mst[d]) begin
        errors++;
        $display("FAIL state dut%0d cyc %0d: got %b expected %b", d, cyc, st[d], mst[d]);
      end
      have_exp = (sbq.size() > 0) && (sbq[0].t == cyc) && (sbq[0].id == d);
      have_act = ((|(pr[d] | rl[d] | lg[d])) !== 1'b0);
      if (have_exp) begin
        e = sbq.pop_front();
        checks++;
        if ({st[d], pr[d], rl[d], lg[d]} !== {e.st, e.pr, e.rl, e.lg}) begin
          errors++;
          $display("FAIL event dut%0d cyc %0d: got st=%b pr=%b rl=%b lg=%b expected st=%b pr=%b rl=%b lg=%b",
                   d, cyc, st[d], pr[d], rl[d], lg[d], e.st, e.pr, e.rl, e.lg);
        end
      end else if (have_act) begin
        checks++;
        errors++;
        $display("FAIL spurious dut%0d cyc %0d: got pr=%b rl=%b lg=%b expected none",
                 d, cyc, pr[d], rl[d], lg[d]);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    bin[0] = 4'h0;
    bin[1] = 4'hF;
    wait_cyc(3);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    wait_cyc(5);

    // clean press on ch0
    bin[0] = 4'b0001;
    wait_cyc(20);

    // bounce on ch1, then stable, then a 7-cycle glitch
    for (int i = 0; i < 10; i++) begin
      bin[0][1] = ~bin[0][1];
      wait_cyc(3);
    end
    bin[0][1] = 1'b1;
    wait_cyc(20);
    bin[0][1] = 1'b0;
    wait_cyc(7);
    bin[0][1] = 1'b1;
    wait_cyc(20);

    // long press on ch2
    bin[0][2] = 1'b1;
    wait_cyc(70);
    bin[0][2] = 1'b0;
    wait_cyc(20);

    // short press on ch3
    bin[0][3] = 1'b1;
    wait_cyc(30);
    bin[0][3] = 1'b0;
    wait_cyc(20);

    bin[0] = 4'h0;
    wait_cyc(20);

    // simultaneous press, then a 5-cycle release blip on ch0
    bin[0] = 4'hF;
    wait_cyc(15);
    bin[0] = 4'hE;
    wait_cyc(5);
    bin[0] = 4'hF;
    wait_cyc(20);
    bin[0] = 4'h0;
    wait_cyc(20);

    // reset mid-count with buttons held
    bin[0] = 4'h5;
    wait_cyc(5);
    rst[0] = 1'b1;
    wait_cyc(3);
    rst[0] = 1'b0;
    wait_cyc(60);
    bin[0] = 4'h0;
    wait_cyc(20);

    // randomized segments of held patterns
    for (int i = 0; i < 40; i++) begin
      bin[0] = 4'($urandom);
      wait_cyc(int'($urandom_range(1, 60)));
    end
    bin[0] = 4'h0;
    wait_cyc(20);

    // active-low instance: ch0 pressed, reset mid-count
    bin[1] = 4'b1110;
    wait_cyc(4);
    rst[1] = 1'b1;
    wait_cyc(4);
    rst[1] = 1'b0;
    wait_cyc(60);
    bin[1] = 4'hF;
    wait_cyc(20);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unmatched expected events, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
